// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, write-back entry and queue-occupancy types for the register-file write side.
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int QDEPTH = 2;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
  typedef enum logic [$clog2(QDEPTH+1)-1:0] {EMPTY, ONE, FULL} qstate_t;
endpackage

// File: rtl/regfile_write_bank_if.sv
// regfile_write_bank_if: write-back request handshake from the pipeline into the register file.
interface regfile_write_bank_if;
  import regfile_pkg::*;
  logic wr_valid;
  logic wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/write_decoder.sv
// write_decoder: 5-to-32 one-hot enable decoder; register 0 is never selected.
module write_decoder
  import regfile_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NUM_REGS-1:0] onehot
);
  assign onehot = (en && addr != '0) ? NUM_REGS'(1) << addr : '0;
endmodule

// File: rtl/regfile_write_bank.sv
// regfile_write_bank: 2-entry in-order write-back queue committing into 32x32 registers with pending bitmap.
module regfile_write_bank
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  regfile_write_bank_if.slave bus,
  input  logic drain_en,
  input  logic flush,
  output logic [NUM_REGS-1:0] pending,
  output logic [DATA_W-1:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7,
  output logic [DATA_W-1:0] Q8, Q9, Q10, Q11, Q12, Q13, Q14, Q15,
  output logic [DATA_W-1:0] Q16, Q17, Q18, Q19, Q20, Q21, Q22, Q23,
  output logic [DATA_W-1:0] Q24, Q25, Q26, Q27, Q28, Q29, Q30, Q31
);
  qstate_t state, state_nx;
  wb_entry_t ent [2];
  logic hd, enq, com;
  logic [NUM_REGS-1:0] we, pend_h, pend_t;
  logic [DATA_W-1:0] regs [NUM_REGS];
  assign bus.wr_ready = state != FULL && !flush;
  assign enq = bus.wr_valid && bus.wr_ready && bus.wr_addr != '0;
  assign com = state != EMPTY && drain_en && !flush;
  always_comb begin
    state_nx = flush ? EMPTY :
               state == EMPTY ? (enq ? ONE : EMPTY) :
               state == ONE ? (enq == com ? ONE : enq ? FULL : EMPTY) :
               (com ? ONE : FULL);
  end
  // Tail slot is the head itself when empty, otherwise the other slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      hd <= 1'b0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else begin
      state <= state_nx;
      hd <= com ? !hd : hd;
      if (enq) ent[state == EMPTY ? hd : !hd] <= '{bus.wr_addr, bus.wr_data};
    end
  end
  write_decoder u_commit (.en(com), .addr(ent[hd].addr), .onehot(we));
  write_decoder u_pend_h (.en(state != EMPTY), .addr(ent[hd].addr), .onehot(pend_h));
  write_decoder u_pend_t (.en(state == FULL), .addr(ent[!hd].addr), .onehot(pend_t));
  assign pending = pend_h | pend_t;
  // we[0] is always 0, so regs[0] stays at its reset value and folds to a constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) if (we[i]) regs[i] <= ent[hd].data;
    end
  end
  assign Q0 = regs[0];   assign Q1 = regs[1];   assign Q2 = regs[2];   assign Q3 = regs[3];
  assign Q4 = regs[4];   assign Q5 = regs[5];   assign Q6 = regs[6];   assign Q7 = regs[7];
  assign Q8 = regs[8];   assign Q9 = regs[9];   assign Q10 = regs[10]; assign Q11 = regs[11];
  assign Q12 = regs[12]; assign Q13 = regs[13]; assign Q14 = regs[14]; assign Q15 = regs[15];
  assign Q16 = regs[16]; assign Q17 = regs[17]; assign Q18 = regs[18]; assign Q19 = regs[19];
  assign Q20 = regs[20]; assign Q21 = regs[21]; assign Q22 = regs[22]; assign Q23 = regs[23];
  assign Q24 = regs[24]; assign Q25 = regs[25]; assign Q26 = regs[26]; assign Q27 = regs[27];
  assign Q28 = regs[28]; assign Q29 = regs[29]; assign Q30 = regs[30]; assign Q31 = regs[31];
endmodule

// File: tb/tb_regfile_write_bank.sv
// tb_regfile_write_bank: randomized scoreboard bench against a queue-and-array model of the write bank.
module tb_regfile_write_bank;
  import regfile_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drain_en = 1'b0;
  logic flush = 1'b0;
  logic [31:0] pending;
  logic [31:0] q [32];
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
  typedef struct packed {logic [31:0][31:0] regs; logic [31:0] pend;} exp_t;
  wr_t mq [$];
  logic [31:0] mregs [32];
  exp_t expq [$];
  regfile_write_bank_if bus ();
  regfile_write_bank dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .drain_en(drain_en), .flush(flush), .pending(pending),
    .Q0(q[0]), .Q1(q[1]), .Q2(q[2]), .Q3(q[3]), .Q4(q[4]), .Q5(q[5]), .Q6(q[6]), .Q7(q[7]),
    .Q8(q[8]), .Q9(q[9]), .Q10(q[10]), .Q11(q[11]), .Q12(q[12]), .Q13(q[13]), .Q14(q[14]), .Q15(q[15]),
    .Q16(q[16]), .Q17(q[17]), .Q18(q[18]), .Q19(q[19]), .Q20(q[20]), .Q21(q[21]), .Q22(q[22]), .Q23(q[23]),
    .Q24(q[24]), .Q25(q[25]), .Q26(q[26]), .Q27(q[27]), .Q28(q[28]), .Q29(q[29]), .Q30(q[30]), .Q31(q[31])
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[k]) p[mq[k].a] = 1'b1;
    return p;
  endfunction
  // One cycle: drive at the falling edge, check ready, advance the model past the next rising edge.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d, input logic de, input logic fl);
    logic rdy;
    exp_t e;
    @(negedge clk);
    bus.wr_valid = v; bus.wr_addr = a; bus.wr_data = d; drain_en = de; flush = fl;
    #1;
    rdy = mq.size() < QDEPTH && !fl;
    check("wr_ready", {31'b0, bus.wr_ready}, {31'b0, rdy});
    if (fl) mq.delete();
    else begin
      if (de && mq.size() > 0) begin
        mregs[mq[0].a] = mq[0].d;
        void'(mq.pop_front());
      end
      if (v && rdy && a != 5'd0) mq.push_back('{a, d});
    end
    for (int i = 0; i < 32; i++) e.regs[i] = mregs[i];
    e.pend = model_pending();
    expq.push_back(e);
  endtask
  task automatic idle(input logic de);
    step(1'b0, 5'd0, 32'd0, de, 1'b0);
  endtask
  task automatic async_reset();
    @(posedge clk);
    #3;
    bus.wr_valid = 1'b0; drain_en = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    mq.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 0; i < 32; i++) check($sformatf("reset_Q%0d", i), q[i], 32'd0);
    check("reset_pending", pending, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        for (int i = 0; i < 32; i++) check($sformatf("Q%0d", i), q[i], e.regs[i]);
        check("pending", pending, e.pend);
      end
    end
  end
  initial begin : driver
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 5'd3, 32'h11, 1'b0, 1'b0);
    step(1'b1, 5'd3, 32'h22, 1'b0, 1'b0);
    step(1'b1, 5'd4, 32'h33, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 5'd7, 32'hA, 1'b0, 1'b0);
    step(1'b1, 5'd9, 32'hB, 1'b0, 1'b0);
    step(1'b1, 5'd12, 32'hC, 1'b1, 1'b1);
    idle(1'b1);
    for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 5'd2, 32'h55, 1'b0, 1'b0);
    step(1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
    async_reset();
    repeat (3) idle(1'b1);
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a;
      a = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, a, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    repeat (4) idle(1'b1);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
